// File: rtl/disp_rdarb_pkg.sv
// rtl/disp_rdarb_pkg.sv - shared state encodings and defaults for the VRAM read arbiter
package disp_rdarb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_t;

    localparam int MAXHOLD_DEF = 4;

endpackage

// File: rtl/disp_rdarb_mux.sv
// rtl/disp_rdarb_mux.sv - owner-select steering of the AR and R channels onto the shared port
module disp_rdarb_mux #(
    parameter int DW = 32
) (
    input  logic          addr_phase,
    input  logic          data_phase,
    input  logic          owner,
    input  logic [31:0]   m0_araddr,
    input  logic [7:0]    m0_arlen,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rlast,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    input  logic [31:0]   m1_araddr,
    input  logic [7:0]    m1_arlen,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rlast,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [31:0]   s_araddr,
    output logic [7:0]    s_arlen,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_rlast,
    input  logic          s_rvalid,
    output logic          s_rready
);

    assign s_araddr   = owner ? m1_araddr : m0_araddr;
    assign s_arlen    = owner ? m1_arlen  : m0_arlen;
    assign s_arvalid  = addr_phase & (owner ? m1_arvalid : m0_arvalid);
    assign m0_arready = addr_phase & ~owner & s_arready;
    assign m1_arready = addr_phase &  owner & s_arready;

    // Data and last fan out to both sides; only the owner's valid is ever raised.
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign m0_rvalid = data_phase & ~owner & s_rvalid;
    assign m1_rvalid = data_phase &  owner & s_rvalid;
    assign s_rready  = data_phase & (owner ? m1_rready : m0_rready);

endmodule

// File: rtl/disp_rdarb.sv
// rtl/disp_rdarb.sv - two-requester AXI4 read arbiter, display priority with bounded starvation
module disp_rdarb
    import disp_rdarb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MAXHOLD = MAXHOLD_DEF
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic [31:0]   M0_ARADDR,
    input  logic [7:0]    M0_ARLEN,
    input  logic          M0_ARVALID,
    output logic          M0_ARREADY,
    output logic [DW-1:0] M0_RDATA,
    output logic          M0_RLAST,
    output logic          M0_RVALID,
    input  logic          M0_RREADY,
    input  logic [31:0]   M1_ARADDR,
    input  logic [7:0]    M1_ARLEN,
    input  logic          M1_ARVALID,
    output logic          M1_ARREADY,
    output logic [DW-1:0] M1_RDATA,
    output logic          M1_RLAST,
    output logic          M1_RVALID,
    input  logic          M1_RREADY,
    output logic [31:0]   S_ARADDR,
    output logic [7:0]    S_ARLEN,
    output logic          S_ARVALID,
    input  logic          S_ARREADY,
    input  logic [DW-1:0] S_RDATA,
    input  logic          S_RLAST,
    input  logic          S_RVALID,
    output logic          S_RREADY,
    output logic          BUSY,
    output logic          OWNER
);

    localparam logic [3:0] HOLD = 4'(MAXHOLD);

    state_t     state;
    logic       owner;
    logic [3:0] starve;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            starve <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (M0_ARVALID && (!M1_ARVALID || starve < HOLD)) begin
                        owner <= 1'b0;
                        state <= S_ADDR;
                        // Only count display wins that actually made requester 1 wait.
                        if (M1_ARVALID && starve != 4'hF)
                            starve <= starve + 4'd1;
                    end else if (M1_ARVALID) begin
                        owner  <= 1'b1;
                        state  <= S_ADDR;
                        starve <= 4'd0;
                    end
                end
                S_ADDR: begin
                    if (S_ARVALID && S_ARREADY)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (S_RVALID && S_RREADY && S_RLAST)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY  = (state != S_IDLE);
    assign OWNER = owner;

    disp_rdarb_mux #(.DW(DW)) u_mux (
        .addr_phase (state == S_ADDR),
        .data_phase (state == S_DATA),
        .owner      (owner),
        .m0_araddr  (M0_ARADDR),
        .m0_arlen   (M0_ARLEN),
        .m0_arvalid (M0_ARVALID),
        .m0_arready (M0_ARREADY),
        .m0_rdata   (M0_RDATA),
        .m0_rlast   (M0_RLAST),
        .m0_rvalid  (M0_RVALID),
        .m0_rready  (M0_RREADY),
        .m1_araddr  (M1_ARADDR),
        .m1_arlen   (M1_ARLEN),
        .m1_arvalid (M1_ARVALID),
        .m1_arready (M1_ARREADY),
        .m1_rdata   (M1_RDATA),
        .m1_rlast   (M1_RLAST),
        .m1_rvalid  (M1_RVALID),
        .m1_rready  (M1_RREADY),
        .s_araddr   (S_ARADDR),
        .s_arlen    (S_ARLEN),
        .s_arvalid  (S_ARVALID),
        .s_arready  (S_ARREADY),
        .s_rdata    (S_RDATA),
        .s_rlast    (S_RLAST),
        .s_rvalid   (S_RVALID),
        .s_rready   (S_RREADY)
    );

endmodule

// File: tb/tb_disp_rdarb.sv
// tb/tb_disp_rdarb.sv - directed self-checking bench for disp_rdarb
module tb_disp_rdarb;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic [31:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic [7:0]  M0_ARLEN, M1_ARLEN, S_ARLEN;
    logic        M0_ARVALID, M0_ARREADY, M0_RLAST, M0_RVALID, M0_RREADY;
    logic        M1_ARVALID, M1_ARREADY, M1_RLAST, M1_RVALID, M1_RREADY;
    logic [31:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic        S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
    logic        BUSY, OWNER;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] dval = 32'hA000_0000;

    always #5 ACLK = ~ACLK;

    disp_rdarb #(.DW(32), .MAXHOLD(4)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARVALID(M0_ARVALID),
        .M0_ARREADY(M0_ARREADY), .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST),
        .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARVALID(M1_ARVALID),
        .M1_ARREADY(M1_ARREADY), .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST),
        .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARVALID(S_ARVALID),
        .S_ARREADY(S_ARREADY), .S_RDATA(S_RDATA), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .BUSY(BUSY), .OWNER(OWNER)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rready(input logic own, input logic v);
        if (own) M1_RREADY = v;
        else     M0_RREADY = v;
    endtask

    // Acts as the VRAM slave for one burst, starting from IDLE with the requests already set up.
    task automatic run_burst(input logic own, input int beats, input int ar_wait,
                             input int gap, input int stall, input logic drop);
        tick();
        chk("grant_busy", BUSY, 1);
        chk("grant_owner", OWNER, own);
        chk("s_arvalid", S_ARVALID, 1);
        chk("s_araddr", S_ARADDR, own ? M1_ARADDR : M0_ARADDR);
        chk("s_arlen", S_ARLEN, own ? M1_ARLEN : M0_ARLEN);
        for (int w = 0; w < ar_wait; w++) begin
            chk("arready_wait", own ? M1_ARREADY : M0_ARREADY, 0);
            tick();
        end
        S_ARREADY = 1'b1;
        #1;
        chk("arready_owner", own ? M1_ARREADY : M0_ARREADY, 1);
        chk("arready_other", own ? M0_ARREADY : M1_ARREADY, 0);
        tick();
        S_ARREADY = 1'b0;
        if (drop) begin
            if (own) M1_ARVALID = 1'b0;
            else     M0_ARVALID = 1'b0;
        end
        #1;
        chk("data_s_arvalid", S_ARVALID, 0);
        for (int i = 0; i < beats; i++) begin
            for (int g = 0; g < gap; g++) begin
                S_RVALID = 1'b0;
                set_rready(own, 1'b0);
                #1;
                chk("gap_s_rready", S_RREADY, 0);
                chk("gap_rvalid", own ? M1_RVALID : M0_RVALID, 0);
                tick();
                set_rready(own, 1'b1);
            end
            if (i == 1) begin
                for (int s = 0; s < stall; s++) begin
                    S_RVALID = 1'b1;
                    S_RDATA  = dval;
                    set_rready(own, 1'b0);
                    #1;
                    chk("stall_s_rready", S_RREADY, 0);
                    chk("stall_rvalid", own ? M1_RVALID : M0_RVALID, 1);
                    chk("stall_other_arready", own ? M0_ARREADY : M1_ARREADY, 0);
                    chk("stall_busy", BUSY, 1);
                    tick();
                end
                set_rready(own, 1'b1);
            end
            S_RVALID = 1'b1;
            S_RDATA  = dval;
            S_RLAST  = (i == beats - 1);
            #1;
            chk("beat_rvalid", own ? M1_RVALID : M0_RVALID, 1);
            chk("beat_rdata", own ? M1_RDATA : M0_RDATA, dval);
            chk("beat_rlast", own ? M1_RLAST : M0_RLAST, (i == beats - 1));
            chk("beat_other_rvalid", own ? M0_RVALID : M1_RVALID, 0);
            chk("beat_s_rready", S_RREADY, 1);
            tick();
            dval = dval + 32'd1;
        end
        S_RVALID = 1'b0;
        S_RLAST  = 1'b0;
        #1;
        chk("end_busy", BUSY, 0);
        chk("end_s_rready", S_RREADY, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        ARST = 1'b1;
        M0_ARADDR = 32'h1000_0000; M0_ARLEN = 8'd3; M0_ARVALID = 1'b1; M0_RREADY = 1'b1;
        M1_ARADDR = 32'h0;         M1_ARLEN = 8'd0; M1_ARVALID = 1'b0; M1_RREADY = 1'b1;
        S_ARREADY = 1'b0; S_RDATA = 32'h0; S_RLAST = 1'b0; S_RVALID = 1'b0;

        // Reset held with a pending display request
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_s_arvalid", S_ARVALID, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_owner", OWNER, 0);
            chk("rst_m0_arready", M0_ARREADY, 0);
        end
        ARST = 1'b0;
        #1;
        chk("release_s_arvalid", S_ARVALID, 0);

        // Single display burst, AR accepted after two wait cycles
        run_burst(1'b0, 4, 2, 0, 0, 1'b1);

        // Both requesting continuously: requester 1 gets every fifth slot
        M0_ARADDR = 32'h1000_0100; M0_ARLEN = 8'd0; M0_ARVALID = 1'b1;
        M1_ARADDR = 32'h2000_0000; M1_ARLEN = 8'd0; M1_ARVALID = 1'b1;
        pat = 10'b10_0001_0000;
        for (int k = 0; k < 10; k++)
            run_burst(pat[k], 1, 0, 0, 0, 1'b0);
        M0_ARVALID = 1'b0;
        M1_ARVALID = 1'b0;

        // Secondary reader alone, data gapped every other cycle
        M1_ARADDR = 32'h2000_0040; M1_ARLEN = 8'd7; M1_ARVALID = 1'b1;
        run_burst(1'b1, 8, 0, 1, 0, 1'b1);

        // Display backpressure with requester 1 pending, then requester 1 served
        M0_ARADDR = 32'h1000_0200; M0_ARLEN = 8'd3; M0_ARVALID = 1'b1;
        M1_ARADDR = 32'h2000_0080; M1_ARLEN = 8'd0; M1_ARVALID = 1'b1;
        run_burst(1'b0, 4, 0, 0, 5, 1'b1);
        run_burst(1'b1, 1, 0, 0, 0, 1'b1);

        // Reset in the middle of a display burst
        M0_ARADDR = 32'h1000_0300; M0_ARLEN = 8'd7; M0_ARVALID = 1'b1;
        M1_ARVALID = 1'b1;
        tick();
        chk("mid_owner", OWNER, 0);
        S_ARREADY = 1'b1;
        tick();
        S_ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            S_RVALID = 1'b1;
            S_RDATA  = dval;
            #1;
            chk("mid_beat", M0_RDATA, dval);
            tick();
            dval = dval + 32'd1;
        end
        chk("mid_starve_pre", dut.starve, 1);
        ARST = 1'b1;
        tick();
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_m0_rvalid", M0_RVALID, 0);
        chk("mid_rst_s_rready", S_RREADY, 0);
        chk("mid_rst_s_arvalid", S_ARVALID, 0);
        chk("mid_rst_m0_arready", M0_ARREADY, 0);
        chk("mid_rst_m1_arready", M1_ARREADY, 0);
        chk("mid_rst_owner", OWNER, 0);
        chk("mid_rst_starve", dut.starve, 0);
        ARST = 1'b0;
        S_RVALID = 1'b0;
        M0_ARVALID = 1'b0;
        M1_ARVALID = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_rdarb.md
Name: disp_rdarb

Overview:
- Two-requester AXI4 read-channel arbiter that shares the single VRAM AXI read port.
- Requester 0 is the display VRAM read controller and has priority. Requester 1 is a secondary reader (drawing/capture engine).
- One burst is in flight at a time. The grant is locked from AR acceptance until the RLAST beat completes.
- A bounded-starvation counter guarantees requester 1 a slot under continuous display traffic.

Parameters:
- DW, 32, read data width in bits
- MAXHOLD, 4, consecutive requester-0 grants allowed while requester 1 waits (1..15)

Ports:
- ACLK  in  1  clock
- ARST  in  1  synchronous active-high reset
- M0_ARADDR  in  32  requester 0 burst address
- M0_ARLEN  in  8  requester 0 burst length-1
- M0_ARVALID  in  1  requester 0 address valid
- M0_ARREADY  out  1  requester 0 address accepted
- M0_RDATA  out  DW  requester 0 read data
- M0_RLAST  out  1  requester 0 last beat
- M0_RVALID  out  1  requester 0 data valid
- M0_RREADY  in  1  requester 0 data ready
- M1_ARADDR, M1_ARLEN, M1_ARVALID, M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID, M1_RREADY: same as M0_*, for requester 1
- S_ARADDR  out  32  shared port address
- S_ARLEN  out  8  shared port length
- S_ARVALID  out  1  shared port address valid
- S_ARREADY  in  1  shared port address ready
- S_RDATA  in  DW  shared port data
- S_RLAST  in  1  shared port last beat
- S_RVALID  in  1  shared port data valid
- S_RREADY  out  1  shared port data ready
- BUSY  out  1  burst owned (state != IDLE)
- OWNER  out  1  current/last owner (0/1)

Behaviour:
- Reset state: IDLE; OWNER=0; starve count=0.
- Reset output values: all VALID/READY outputs and BUSY are 0.
- States:
  - IDLE: no grant.
  - ADDR: grant held, AR forwarded.
  - DATA: R beats routed to the owner.
- IDLE arbitration (registered, evaluated each cycle):
  - If M0_ARVALID and (!M1_ARVALID or starve<MAXHOLD): OWNER<=0, go to ADDR.
  - Else if M1_ARVALID: OWNER<=1, go to ADDR.
  - Else stay in IDLE.
- Starve counter:
  - +1 (saturating at 15) when requester 0 is granted while M1_ARVALID=1.
  - Cleared when requester 1 is granted.
  - Unchanged otherwise.
- ADDR:
  - S_ARADDR/S_ARLEN/S_ARVALID driven combinationally from the owner.
  - Owner's ARREADY = S_ARREADY; the non-owner's ARREADY = 0.
  - On S_ARVALID & S_ARREADY, go to DATA.
- DATA:
  - Owner's RDATA/RLAST/RVALID come from S_*; S_RREADY = owner's RREADY.
  - Non-owner's RVALID = 0; its RDATA may be the same value.
  - On S_RVALID & S_RREADY & S_RLAST, go to IDLE.
- Outside ADDR: S_ARVALID=0 and both ARREADY=0. Outside DATA: S_RREADY=0 and both RVALID=0.
- Latency: ARVALID seen in IDLE at cycle N gives S_ARVALID=1 at N+1. The earliest next grant is the cycle after the RLAST handshake, so there is one idle cycle between bursts.
- Simultaneous requests: requester 0 wins unless starve==MAXHOLD.
- Requester 0 deasserting ARVALID before acceptance is an AXI violation and is not handled.
- S_ARLEN is passed through unmodified; beats are not counted, and RLAST alone terminates the burst.
- Reset mid-burst: immediate return to IDLE with outputs 0. The VRAM slave shares ARST, so no orphan beats are expected.

Decomposition:
- Package disp_rdarb_pkg holds:
  - state encodings (S_IDLE=2'b00, S_ADDR=2'b01, S_DATA=2'b10)
  - default MAXHOLD
- Optional sub-module disp_rdarb_mux holds the pure combinational owner-select muxing for the AR/R channels. The FSM and counter stay in the top.

Test Plan:
1. Reset: assert ARST 3 cycles with M0_ARVALID=1 -> S_ARVALID=0, BUSY=0, OWNER=0 throughout; first S_ARVALID 1 cycle after release.
2. Single M0 burst: addr 0x1000_0000, ARLEN=3, S_ARREADY after 2 cycles -> S_ARADDR=0x1000_0000, 4 beats on M0_R*, M1_RVALID=0, BUSY falls cycle after RLAST.
3. Simultaneous M0/M1, MAXHOLD=4, M0 continuously requesting -> grant order 0,0,0,0,1,0,0,0,0,1.
4. M1 alone: addr 0x2000_0040, ARLEN=7, S_RVALID gapped every other cycle -> all 8 beats to M1 in order, S_RREADY follows M1_RREADY.
5. Backpressure: M0_RREADY low for 5 cycles mid-burst -> S_RREADY=0, no beat lost or duplicated, M1 request held pending until RLAST.
6. Reset mid-DATA (after beat 2 of 8) -> next cycle state IDLE, all VALID/READY 0, starve count 0.
